// File: rtl/bcd_timer_ud.sv
// HH:MM:SS BCD timekeeper. It counts up or down and has a prescaler, a stop-at-zero
// option and an alarm compare. All state is clocked by cp_i; carries act as enables.

module bcd_field #(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic [7:0] q_i,
   input  logic       up_i,
   input  logic [7:0] d_i,
   output logic [7:0] nxt_o,
   output logic       wrap_o,
   output logic [7:0] ld_o
);
   always_comb begin
      nxt_o  = q_i;
      wrap_o = up_i ? (q_i == MAX) : (q_i == 8'h00);
      if (up_i) begin
         if (q_i == MAX)            nxt_o = 8'h00;
         else if (q_i[3:0] == 4'd9) nxt_o = {q_i[7:4] + 4'd1, 4'd0};
         else                       nxt_o = {q_i[7:4], q_i[3:0] + 4'd1};
      end else begin
         if (q_i == 8'h00)          nxt_o = MAX;
         else if (q_i[3:0] == 4'd0) nxt_o = {q_i[7:4] - 4'd1, 4'd9};
         else                       nxt_o = {q_i[7:4], q_i[3:0] - 4'd1};
      end
      // Digit values are checked first, so the binary compare with MAX gives the BCD order.
      ld_o = (d_i[7:4] <= 4'd9 && d_i[3:0] <= 4'd9 && d_i <= MAX) ? d_i : 8'h00;
   end
endmodule

module bcd_timer_ud #(
   parameter int unsigned DIV          = 1,
   parameter logic [7:0]  S_MAX        = 8'h59,
   parameter logic [7:0]  M_MAX        = 8'h59,
   parameter logic [7:0]  H_MAX        = 8'h23,
   parameter bit          STOP_AT_ZERO = 1'b1
) (
   input  logic       cp_i,
   input  logic       cr_i,
   input  logic       ce_i,
   input  logic       up_i,
   input  logic       pe_i,
   input  logic [7:0] d_h_i,
   input  logic [7:0] d_m_i,
   input  logic [7:0] d_s_i,
   input  logic       alm_en_i,
   input  logic [7:0] a_h_i,
   input  logic [7:0] a_m_i,
   input  logic [7:0] a_s_i,
   output logic [7:0] q_h_o,
   output logic [7:0] q_m_o,
   output logic [7:0] q_s_o,
   output logic       tc_s_o,
   output logic       tc_m_o,
   output logic       tc_h_o,
   output logic       alarm_o,
   output logic       done_o,
   output logic       zero_o
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    q_h_q, q_m_q, q_s_q, q_h_d, q_m_d, q_s_d;
   logic          tc_s_q, tc_m_q, tc_h_q, alarm_q, done_q;
   logic          tc_s_d, tc_m_d, tc_h_d, alarm_d, done_d;
   logic [7:0]    nxt_h, nxt_m, nxt_s, ld_h, ld_m, ld_s;
   logic          wrap_h, wrap_m, wrap_s;
   logic          tick, hold, step_s, step_m, step_h;

   bcd_field #(.MAX(S_MAX)) u_s (.q_i(q_s_q), .up_i(up_i), .d_i(d_s_i),
                                 .nxt_o(nxt_s), .wrap_o(wrap_s), .ld_o(ld_s));
   bcd_field #(.MAX(M_MAX)) u_m (.q_i(q_m_q), .up_i(up_i), .d_i(d_m_i),
                                 .nxt_o(nxt_m), .wrap_o(wrap_m), .ld_o(ld_m));
   bcd_field #(.MAX(H_MAX)) u_h (.q_i(q_h_q), .up_i(up_i), .d_i(d_h_i),
                                 .nxt_o(nxt_h), .wrap_o(wrap_h), .ld_o(ld_h));

   assign zero_o = ({q_h_q, q_m_q, q_s_q} == 24'h0);

   always_comb begin
      tick  = ce_i && (pre_q == PW'(DIV - 1));
      pre_d = pre_q;
      if (ce_i) pre_d = tick ? '0 : pre_q + PW'(1);

      // In stop mode, a down tick at 00:00:00 is discarded completely.
      hold   = STOP_AT_ZERO && !up_i && zero_o;
      step_s = tick && !hold;
      step_m = step_s && wrap_s;
      step_h = step_m && wrap_m;

      q_s_d = step_s ? nxt_s : q_s_q;
      q_m_d = step_m ? nxt_m : q_m_q;
      q_h_d = step_h ? nxt_h : q_h_q;

      tc_s_d  = step_s && wrap_s;
      tc_m_d  = step_m && wrap_m;
      tc_h_d  = step_h && wrap_h;
      alarm_d = step_s && alm_en_i && ({q_h_d, q_m_d, q_s_d} == {a_h_i, a_m_i, a_s_i});
      done_d  = step_s && !up_i && ({q_h_d, q_m_d, q_s_d} == 24'h0);

      if (pe_i) begin
         q_h_d   = ld_h;
         q_m_d   = ld_m;
         q_s_d   = ld_s;
         pre_d   = '0;
         tc_s_d  = 1'b0;
         tc_m_d  = 1'b0;
         tc_h_d  = 1'b0;
         alarm_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge cp_i) begin
      if (cr_i) begin
         pre_q   <= '0;
         q_h_q   <= 8'h00;
         q_m_q   <= 8'h00;
         q_s_q   <= 8'h00;
         tc_s_q  <= 1'b0;
         tc_m_q  <= 1'b0;
         tc_h_q  <= 1'b0;
         alarm_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         q_h_q   <= q_h_d;
         q_m_q   <= q_m_d;
         q_s_q   <= q_s_d;
         tc_s_q  <= tc_s_d;
         tc_m_q  <= tc_m_d;
         tc_h_q  <= tc_h_d;
         alarm_q <= alarm_d;
         done_q  <= done_d;
      end
   end

   assign q_h_o   = q_h_q;
   assign q_m_o   = q_m_q;
   assign q_s_o   = q_s_q;
   assign tc_s_o  = tc_s_q;
   assign tc_m_o  = tc_m_q;
   assign tc_h_o  = tc_h_q;
   assign alarm_o = alarm_q;
   assign done_o  = done_q;
endmodule

// File: tb/tb_bcd_timer_ud.sv
// Random and directed bench for bcd_timer_ud. Two instances are used: one with DIV=1 and
// stop-at-zero, one with DIV=4 and wrap-around. Both are checked against a model that counts seconds of the day.
module tb_bcd_timer_ud;
   logic       clk = 1'b0;
   logic       cr, ce, up, pe, alm_en;
   logic [7:0] dh, dm, ds, ah, am, as_;
   logic [7:0] qh [2], qm [2], qs [2];
   logic       tcs [2], tcm [2], tch [2], alm [2], dn [2], zr [2];

   int checks = 0, errors = 0;
   int mt [2], mpre [2];
   logic [4:0] mf [2];   // {tc_s, tc_m, tc_h, alarm, done}

   always #5 clk = ~clk;

   bcd_timer_ud #(.DIV(1), .STOP_AT_ZERO(1'b1)) dut0 (
      .cp_i(clk), .cr_i(cr), .ce_i(ce), .up_i(up), .pe_i(pe),
      .d_h_i(dh), .d_m_i(dm), .d_s_i(ds), .alm_en_i(alm_en),
      .a_h_i(ah), .a_m_i(am), .a_s_i(as_),
      .q_h_o(qh[0]), .q_m_o(qm[0]), .q_s_o(qs[0]),
      .tc_s_o(tcs[0]), .tc_m_o(tcm[0]), .tc_h_o(tch[0]),
      .alarm_o(alm[0]), .done_o(dn[0]), .zero_o(zr[0]));

   bcd_timer_ud #(.DIV(4), .STOP_AT_ZERO(1'b0)) dut1 (
      .cp_i(clk), .cr_i(cr), .ce_i(ce), .up_i(up), .pe_i(pe),
      .d_h_i(dh), .d_m_i(dm), .d_s_i(ds), .alm_en_i(alm_en),
      .a_h_i(ah), .a_m_i(am), .a_s_i(as_),
      .q_h_o(qh[1]), .q_m_o(qm[1]), .q_s_o(qs[1]),
      .tc_s_o(tcs[1]), .tc_m_o(tcm[1]), .tc_h_o(tch[1]),
      .alarm_o(alm[1]), .done_o(dn[1]), .zero_o(zr[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int fdec(input logic [7:0] v, input int mx);
      int hi, lo;
      hi = int'(v[7:4]); lo = int'(v[3:0]);
      if (hi > 9 || lo > 9 || hi * 10 + lo > mx) return 0;
      return hi * 10 + lo;
   endfunction

   function automatic int alarm_sec();
      return fdec(ah, 23) * 3600 + fdec(am, 59) * 60 + fdec(as_, 59);
   endfunction

   task automatic model(input int k);
      int divv, old, s0, m0, h0;
      bit stop, tick, ts, tm, th;
      divv = (k == 0) ? 1 : 4;
      stop = (k == 0);
      mf[k] = '0;
      if (cr) begin
         mt[k] = 0; mpre[k] = 0;
      end else if (pe) begin
         mt[k] = fdec(dh, 23) * 3600 + fdec(dm, 59) * 60 + fdec(ds, 59);
         mpre[k] = 0;
      end else begin
         tick = ce && (mpre[k] == divv - 1);
         if (ce) mpre[k] = tick ? 0 : mpre[k] + 1;
         if (tick && !(stop && !up && mt[k] == 0)) begin
            old = mt[k];
            mt[k] = up ? (old + 1) % 86400 : (old + 86399) % 86400;
            s0 = old % 60; m0 = (old / 60) % 60; h0 = old / 3600;
            ts = up ? (s0 == 59) : (s0 == 0);
            tm = ts && (up ? (m0 == 59) : (m0 == 0));
            th = tm && (up ? (h0 == 23) : (h0 == 0));
            mf[k] = {ts, tm, th, alm_en && (mt[k] == alarm_sec()), !up && (mt[k] == 0)};
         end
      end
   endtask

   task automatic step();
      model(0);
      model(1);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("q%0d", k), {8'h0, qh[k], qm[k], qs[k]}, {8'h0, to_bcd(mt[k])});
         chk($sformatf("flags%0d", k), {27'h0, tcs[k], tcm[k], tch[k], alm[k], dn[k]},
             {27'h0, mf[k]});
         chk($sformatf("zero%0d", k), {31'h0, zr[k]}, {31'h0, mt[k] == 0});
      end
   endtask

   task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      pe = 1'b1; dh = h; dm = m; ds = s;
      step();
      pe = 1'b0;
   endtask

   initial begin
      int r, t;
      cr = 1'b1; ce = 1'b0; up = 1'b1; pe = 1'b0; alm_en = 1'b0;
      dh = 0; dm = 0; ds = 0; ah = 8'h99; am = 8'h99; as_ = 8'h99;
      mt = '{0, 0}; mpre = '{0, 0}; mf = '{5'h0, 5'h0};
      @(negedge clk);
      step();
      chk("rst_q", {8'h0, qh[0], qm[0], qs[0]}, 32'h0);
      chk("rst_zero", {31'h0, zr[0]}, 32'h1);
      cr = 1'b0;

      // full wrap on the DIV=1 instance
      load(8'h23, 8'h59, 8'h58);
      ce = 1'b1; up = 1'b1;
      step(); step();
      chk("wrap_q", {8'h0, qh[0], qm[0], qs[0]}, 32'h0);
      chk("wrap_tc", {29'h0, tcs[0], tcm[0], tch[0]}, 32'h7);
      step();
      chk("wrap_tc_gone", {29'h0, tcs[0], tcm[0], tch[0]}, 32'h0);

      // countdown with stop at zero
      ce = 1'b0;
      load(8'h00, 8'h01, 8'h00);
      ce = 1'b1; up = 1'b0;
      step();
      chk("cd_first", {8'h0, qh[0], qm[0], qs[0], 7'h0, tcs[0]}, {8'h0, 24'h000059, 8'h01});
      for (int i = 0; i < 59; i++) step();
      chk("cd_done", {23'h0, zr[0], 7'h0, dn[0]}, 32'h0101);
      step();
      chk("cd_hold", {8'h0, qh[0], qm[0], qs[0], 3'h0, tcs[0], tcm[0], tch[0], alm[0], dn[0]},
          32'h0);

      // prescaler on DIV=4 instance: CE pattern 1,0,1,1,1
      ce = 1'b0; up = 1'b1;
      load(8'h00, 8'h00, 8'h00);
      ce = 1'b1; step();
      ce = 1'b0; step();
      ce = 1'b1; step(); step();
      chk("pre_before", {24'h0, qs[1]}, 32'h00);
      step();
      chk("pre_tick", {24'h0, qs[1]}, 32'h01);

      // alarm by counting and by loading
      ce = 1'b0; alm_en = 1'b1; ah = 8'h12; am = 8'h00; as_ = 8'h05;
      load(8'h12, 8'h00, 8'h04);
      ce = 1'b1; step();
      chk("alarm_tick", {31'h0, alm[0]}, 32'h1);
      ce = 1'b0;
      load(8'h12, 8'h00, 8'h05);
      chk("alarm_load", {31'h0, alm[0]}, 32'h0);

      // bad digits/ranges, then CR and PE together
      load(8'h25, 8'h30, 8'h6A);
      chk("bad_load", {8'h0, qh[0], qm[0], qs[0]}, 32'h003000);
      cr = 1'b1;
      load(8'h11, 8'h22, 8'h33);
      cr = 1'b0;
      chk("cr_pe", {8'h0, qh[0], qm[0], qs[0]}, 32'h0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         r  = $urandom_range(0, 199);
         cr = (r == 0);
         pe = (r >= 1 && r <= 8);
         if (pe) begin
            if ($urandom_range(0, 3) == 0) begin
               dh = 8'($urandom); dm = 8'($urandom); ds = 8'($urandom);
            end else begin
               case ($urandom_range(0, 2))
                  0:       t = $urandom_range(0, 5);
                  1:       t = 86399 - $urandom_range(0, 5);
                  default: t = $urandom_range(0, 86399);
               endcase
               {dh, dm, ds} = to_bcd(t);
            end
         end
         ce = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 79) == 0) up = ~up;
         alm_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0)
            {ah, am, as_} = to_bcd((mt[0] + 86400 + $urandom_range(0, 6) - 3) % 86400);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
